// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NUM_CH runtime-programmable clock dividers on
// clk16f, with rising-edge ticks, an alignment strobe and a
// glitch-free ratio loader.
//
// Ports:
//   clk16f   - fast source clock, all logic on its posedge
//   reset    - asynchronous active-high reset
//   div_i    - new per-channel field values, channel i at [i*DIV_W +: DIV_W]
//   div_load - single-cycle request to capture div_i into the shadow
//   ch_en    - per-channel run enable
//   clk_o    - registered divided clocks
//   tick_o   - one-cycle pulse in the cycle clk_o[i] goes 0->1
//   align_o  - one-cycle pulse when every active channel ticks together
//   busy_o   - a load is pending and not yet applied
//
// Build option: define ODD_DIV_EN to make each field the full period P
// (high ceil(P/2), low floor(P/2)) instead of the half-period.
module clk_div_bank #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DIV_W  = 8,
    parameter logic [NUM_CH*DIV_W-1:0] DEF_HALF = {8'd8, 8'd4, 8'd2}
) (
    input  logic                    clk16f,
    input  logic                    reset,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic                    div_load,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic                    align_o,
    output logic                    busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [NUM_CH*DIV_W-1:0] half_q, half_d;
    logic [NUM_CH*DIV_W-1:0] shad_q, shad_d;
    logic [NUM_CH*DIV_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]       clk_q, clk_d;
    logic [NUM_CH-1:0]       tick_q, tick_d;
    logic                    align_q, align_d;

    logic [NUM_CH-1:0] act;
    logic [NUM_CH-1:0] act_new;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic              apply;

    // A field value that produces a running clock.
    function automatic logic field_on(input logic [DIV_W-1:0] v);
`ifdef ODD_DIV_EN
        return v > DIV_W'(1);
`else
        return v != '0;
`endif
    endfunction

    // Per-channel edge decode: rise/fall say what the next edge does.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] h;
        logic [DIV_W-1:0] c;

        assign h          = half_q[g*DIV_W +: DIV_W];
        assign c          = cnt_q[g*DIV_W +: DIV_W];
        assign act[g]     = ch_en[g] && field_on(h);
        assign act_new[g] = ch_en[g] && field_on(shad_q[g*DIV_W +: DIV_W]);

`ifdef ODD_DIV_EN
        // Counter spans the whole period; fall after ceil(P/2) high cycles.
        logic [DIV_W:0] hi;

        assign hi      = ({1'b0, h} + 1'b1) >> 1;
        assign fall[g] = clk_q[g] && ({1'b0, c} == hi - 1'b1);
        assign rise[g] = !clk_q[g] && (c == h - 1'b1);
`else
        // Counter spans one half-period and restarts on every toggle.
        logic last;

        assign last    = (c == h - 1'b1);
        assign fall[g] = clk_q[g] && last;
        assign rise[g] = !clk_q[g] && last;
`endif
    end

    // Load FSM: state register.
    always_ff @(posedge clk16f or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load FSM: next state. Apply only just before channel 0 would rise,
    // so its clock is already high-bound and nothing gets a runt pulse.
    always_comb begin
        state_d = state_q;
        apply   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (div_load) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                apply = !act[0] || rise[0];
                // A load landing on the apply cycle starts a fresh request.
                if (apply && !div_load) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Load FSM: outputs.
    always_comb begin
        busy_o = (state_q == PEND);
        shad_d = div_load ? div_i : shad_q;
    end

    // Divider datapath.
    always_comb begin
        half_d = half_q;
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!act[i]) begin
                cnt_d[i*DIV_W +: DIV_W] = '0;
                clk_d[i]                = 1'b1;
            end else if (rise[i]) begin
                cnt_d[i*DIV_W +: DIV_W] = '0;
                clk_d[i]                = 1'b1;
                tick_d[i]               = 1'b1;
            end else if (fall[i]) begin
`ifdef ODD_DIV_EN
                cnt_d[i*DIV_W +: DIV_W] = cnt_q[i*DIV_W +: DIV_W] + 1'b1;
`else
                cnt_d[i*DIV_W +: DIV_W] = '0;
`endif
                clk_d[i]                = 1'b0;
            end else begin
                cnt_d[i*DIV_W +: DIV_W] = cnt_q[i*DIV_W +: DIV_W] + 1'b1;
            end
        end
        align_d = (|act) && (&(tick_d | ~act));
        // Apply restarts every channel in phase, high, with a common tick.
        if (apply) begin
            half_d  = shad_q;
            cnt_d   = '0;
            clk_d   = '1;
            tick_d  = act_new;
            align_d = |act_new;
        end
    end

    always_ff @(posedge clk16f or posedge reset) begin
        if (reset) begin
            half_q  <= DEF_HALF;
            shad_q  <= DEF_HALF;
            cnt_q   <= '0;
            clk_q   <= '1;
            tick_q  <= '0;
            align_q <= 1'b0;
        end else begin
            half_q  <= half_d;
            shad_q  <= shad_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            align_q <= align_d;
        end
    end

    assign clk_o   = clk_q;
    assign tick_o  = tick_q;
    assign align_o = align_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: self-checking bench for clk_div_bank with a
// period/phase reference model, a vector table and directed sequences.
module tb_clk_div_bank;

    localparam int NC = 3;
    localparam int DW = 8;
    localparam logic [NC*DW-1:0] DEF = {8'd8, 8'd4, 8'd2};

    logic           clk16f = 1'b0;
    logic           reset = 1'b1;
    logic [23:0]    div_i = '0;
    logic           div_load = 1'b0;
    logic [2:0]     ch_en = '0;
    logic [2:0]     clk_o;
    logic [2:0]     tick_o;
    logic           align_o;
    logic           busy_o;

    int checks = 0;
    int errors = 0;

    clk_div_bank #(
        .NUM_CH   (NC),
        .DIV_W    (DW),
        .DEF_HALF (DEF)
    ) dut (
        .clk16f   (clk16f),
        .reset    (reset),
        .div_i    (div_i),
        .div_load (div_load),
        .ch_en    (ch_en),
        .clk_o    (clk_o),
        .tick_o   (tick_o),
        .align_o  (align_o),
        .busy_o   (busy_o)
    );

    always #5 clk16f = ~clk16f;

    // Reference model: position within each channel's period since restart.
    int m_p  [NC];
    int m_h  [NC];
    int m_sh [NC];
    bit m_tk [NC];
    bit m_al;
    bit m_pend;

    function automatic bit valid_f(int v);
`ifdef ODD_DIV_EN
        return v > 1;
`else
        return v != 0;
`endif
    endfunction

    function automatic int per_f(int v);
`ifdef ODD_DIV_EN
        return v;
`else
        return 2 * v;
`endif
    endfunction

    function automatic int hi_f(int v);
`ifdef ODD_DIV_EN
        return (v + 1) / 2;
`else
        return v;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_p[i]  = 0;
            m_h[i]  = int'(DEF[i*DW +: DW]);
            m_sh[i] = m_h[i];
            m_tk[i] = 1'b0;
        end
        m_al   = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic model_edge(input logic [2:0] en, input bit ld, input logic [23:0] dv);
        bit act [NC];
        bit apply;
        bit any;
        bit all;
        for (int i = 0; i < NC; i++) act[i] = en[i] && valid_f(m_h[i]);
        apply = m_pend && (!act[0] || (m_p[0] == per_f(m_h[0]) - 1));
        any = 1'b0;
        all = 1'b1;
        if (apply) begin
            for (int i = 0; i < NC; i++) begin
                m_h[i]  = m_sh[i];
                m_p[i]  = 0;
                m_tk[i] = en[i] && valid_f(m_h[i]);
                any     = any | m_tk[i];
            end
            m_al = any;
            m_pend = 1'b0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (act[i]) begin
                    m_p[i]  = (m_p[i] + 1) % per_f(m_h[i]);
                    m_tk[i] = (m_p[i] == 0);
                    any     = 1'b1;
                    if (!m_tk[i]) all = 1'b0;
                end else begin
                    m_p[i]  = 0;
                    m_tk[i] = 1'b0;
                end
            end
            m_al = any && all;
        end
        if (ld) begin
            for (int i = 0; i < NC; i++) m_sh[i] = int'(dv[i*DW +: DW]);
            m_pend = 1'b1;
        end
    endtask

    function automatic logic [7:0] mexp();
        logic [2:0] c;
        logic [2:0] t;
        for (int i = 0; i < NC; i++) begin
            c[i] = (m_p[i] == 0) || (m_p[i] < hi_f(m_h[i]));
            t[i] = m_tk[i];
        end
        return {c, t, m_al, m_pend};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic [2:0] en, input logic ld, input logic [23:0] dv);
        ch_en    = en;
        div_load = ld;
        div_i    = dv;
        @(posedge clk16f);
        model_edge(en, ld, dv);
        #1;
        chk("model", {24'd0, clk_o, tick_o, align_o, busy_o}, {24'd0, mexp()});
    endtask

    typedef struct {
        logic [2:0] en;
        logic [2:0] clk;
        logic [2:0] tick;
        logic       align;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int n;
        int t0;
        int t1;
        int t2;
        int ta;
        int na;
        int applies;
        logic prevb;
        logic [5:0] pat;
        logic [2:0] ren;
        logic [23:0] rdv;

        tbl[0]  = '{3'b111, 3'b111, 3'b000, 1'b0};
        tbl[1]  = '{3'b111, 3'b110, 3'b000, 1'b0};
        tbl[2]  = '{3'b111, 3'b110, 3'b000, 1'b0};
        tbl[3]  = '{3'b111, 3'b101, 3'b001, 1'b0};
        tbl[4]  = '{3'b111, 3'b101, 3'b000, 1'b0};
        tbl[5]  = '{3'b111, 3'b100, 3'b000, 1'b0};
        tbl[6]  = '{3'b111, 3'b100, 3'b000, 1'b0};
        tbl[7]  = '{3'b111, 3'b011, 3'b011, 1'b0};
        tbl[8]  = '{3'b111, 3'b011, 3'b000, 1'b0};
        tbl[9]  = '{3'b111, 3'b010, 3'b000, 1'b0};
        tbl[10] = '{3'b111, 3'b010, 3'b000, 1'b0};
        tbl[11] = '{3'b111, 3'b001, 3'b001, 1'b0};
        tbl[12] = '{3'b111, 3'b001, 3'b000, 1'b0};
        tbl[13] = '{3'b111, 3'b000, 3'b000, 1'b0};
        tbl[14] = '{3'b111, 3'b000, 3'b000, 1'b0};
        tbl[15] = '{3'b111, 3'b111, 3'b111, 1'b1};

        ch_en = 3'b111;
        #12;
        chk("reset_state", {24'd0, clk_o, tick_o, align_o, busy_o}, 32'h000000E0);
        reset = 1'b0;
        model_reset();

`ifndef ODD_DIV_EN
        // Default ratios straight out of reset.
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].en, 1'b0, '0);
            chk("tbl", {25'd0, clk_o, tick_o, align_o},
                {25'd0, tbl[i].clk, tbl[i].tick, tbl[i].align});
        end

        // Channel 1 disabled, then re-enabled.
        for (int k = 0; k < 10; k++) begin
            cycle(3'b101, 1'b0, '0);
            chk("dis_hold", {30'd0, clk_o[1], tick_o[1]}, 32'd2);
        end
        n = -1;
        for (int k = 1; k <= 12; k++) begin
            cycle(3'b111, 1'b0, '0);
            if (n < 0 && !clk_o[1]) n = k;
        end
        chk("reen_fall", n, 4);

        // Load mid-period, apply at channel 0's rising edge.
        cycle(3'b111, 1'b0, '0);
        cycle(3'b111, 1'b1, {8'd3, 8'd3, 8'd1});
        chk("busy_set", {31'd0, busy_o}, 32'd1);
        for (int k = 0; k < 40 && busy_o; k++) cycle(3'b111, 1'b0, '0);
        chk("apply_seen", {31'd0, busy_o}, 32'd0);
        chk("apply_out", {25'd0, clk_o, tick_o, align_o}, 32'h7F);
        t0 = -1; t1 = -1; t2 = -1;
        for (int k = 1; k <= 20; k++) begin
            cycle(3'b111, 1'b0, '0);
            if (t0 < 0 && tick_o[0]) t0 = k;
            if (t1 < 0 && tick_o[1]) t1 = k;
            if (t2 < 0 && tick_o[2]) t2 = k;
        end
        chk("per0", t0, 2);
        chk("per1", t1, 6);
        chk("per2", t2, 6);

        // Two loads while pending: the second one wins, applied once.
        for (int k = 0; k < 10 && !tick_o[0]; k++) cycle(3'b111, 1'b0, '0);
        cycle(3'b111, 1'b0, '0);
        cycle(3'b111, 1'b1, {8'd1, 8'd1, 8'd1});
        cycle(3'b111, 1'b1, {8'd2, 8'd2, 8'd2});
        applies = 0; ta = -1; t0 = -1;
        prevb = busy_o;
        for (int k = 1; k <= 20; k++) begin
            cycle(3'b111, 1'b0, '0);
            if (prevb && !busy_o) begin
                applies++;
                ta = k;
            end
            if (ta > 0 && k > ta && t0 < 0 && tick_o[0]) t0 = k - ta;
            prevb = busy_o;
        end
        chk("one_apply", applies, 1);
        chk("last_wins", t0, 4);

        // Channel 0 field zero: held high, align from channels 1 and 2.
        cycle(3'b111, 1'b1, {8'd2, 8'd2, 8'd0});
        for (int k = 0; k < 40 && busy_o; k++) cycle(3'b111, 1'b0, '0);
        chk("zero_applied", {31'd0, busy_o}, 32'd0);
        na = 0;
        for (int k = 0; k < 16; k++) begin
            cycle(3'b111, 1'b0, '0);
            chk("ch0_stuck", {30'd0, clk_o[0], tick_o[0]}, 32'd2);
            if (align_o) na++;
        end
        chk("align_no0", na, 4);

        // Reset while a load is pending.
        cycle(3'b111, 1'b1, {8'd2, 8'd2, 8'd20});
        cycle(3'b111, 1'b0, '0);
        cycle(3'b111, 1'b1, {8'd1, 8'd1, 8'd1});
        chk("busy_pre_rst", {31'd0, busy_o}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async", {24'd0, clk_o, tick_o, align_o, busy_o}, 32'h000000E0);
        @(negedge clk16f);
        reset = 1'b0;
        model_reset();
        t0 = -1; t1 = -1; t2 = -1;
        for (int k = 1; k <= 20; k++) begin
            cycle(3'b111, 1'b0, '0);
            if (t0 < 0 && tick_o[0]) t0 = k;
            if (t1 < 0 && tick_o[1]) t1 = k;
            if (t2 < 0 && tick_o[2]) t2 = k;
        end
        chk("rst_per0", t0, 4);
        chk("rst_per1", t1, 8);
        chk("rst_per2", t2, 16);
`else
        // Odd ratio: P=3 gives 2 high, 1 low.
        for (int k = 0; k < 5; k++) cycle(3'b111, 1'b0, '0);
        cycle(3'b000, 1'b1, {8'd0, 8'd0, 8'd3});
        cycle(3'b000, 1'b0, '0);
        chk("odd_applied", {31'd0, busy_o}, 32'd0);
        pat = '0;
        for (int k = 0; k < 6; k++) begin
            cycle(3'b001, 1'b0, '0);
            pat[k] = clk_o[0];
        end
        chk("odd_p3", {26'd0, pat}, 32'h2D);
`endif

        // Randomized enables and loads against the model.
        ren = 3'b111;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) ren = 3'($urandom_range(0, 7));
            for (int i = 0; i < NC; i++) rdv[i*DW +: DW] = 8'($urandom_range(0, 5));
            cycle(ren, ($urandom_range(0, 24) == 0), rdv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
